uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLOCK_FREQ, default 50_000_000, ACLK frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate; CLOCKS_PER_BIT = CLOCK_FREQ / BAUD_RATE (integer divide; 434 at defaults).
REQ-003 ACLK  input  1  clock; all state changes on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 RXD  input  1  serial line, asynchronous to ACLK, idle high.
REQ-006 RX_DATA  output  8  received byte holding register.
REQ-007 RX_DATA_VALID  output  1  holding register full.
REQ-008 RX_DATA_READ  input  1  consumer pulse; pops holding register.
REQ-009 RX_FRAME_ERR  output  1  sticky: stop bit sampled low.
REQ-010 RX_OVERRUN  output  1  sticky: good frame arrived while holding register full and not being read.
REQ-011 ERR_CLEAR  input  1  clears both sticky flags.
REQ-012 UART_RTS  output  1  high when RX_DATA_VALID = 0, i.e. ready to accept a byte.
REQ-013 RX_IDLE  output  1  high when FSM is in IDLE.

Function
REQ-014 RXD SHALL pass through a 2-flop synchronizer (both flops reset to 1); all FSM decisions use the synchronized value rxs.
REQ-015 FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT, BREAK_WAIT.
REQ-016 IDLE: rxs = 0 -> START_BIT, bit counter cleared to 0; otherwise stay.
REQ-017 START_BIT: counter increments each cycle; at counter = CLOCKS_PER_BIT/2 - 1, rxs = 0 -> DATA_BITS with counter and bit index cleared; rxs = 1 -> IDLE (false start, nothing reported).
REQ-018 DATA_BITS: counter increments; at counter = CLOCKS_PER_BIT - 1, rxs sampled into shift register bit [bitIndex] (LSB first), counter cleared, bitIndex incremented; after sampling bit 7 -> STOP_BIT.
REQ-019 bitIndex SHALL be 3 bits, wrapping 7 -> 0 only by explicit clear; counter width $clog2(CLOCKS_PER_BIT).
REQ-020 STOP_BIT: at counter = CLOCKS_PER_BIT - 1, rxs = 1 -> good frame, IDLE; rxs = 0 -> RX_FRAME_ERR set, byte discarded, BREAK_WAIT.
REQ-021 BREAK_WAIT: stay until rxs = 1, then IDLE (no restart on a held-low line).
REQ-022 Good frame with RX_DATA_VALID = 0, or RX_DATA_VALID = 1 and RX_DATA_READ = 1 same cycle: RX_DATA loaded, RX_DATA_VALID = 1 next cycle, no overrun.
REQ-023 Good frame with RX_DATA_VALID = 1 and RX_DATA_READ = 0: new byte discarded, RX_DATA unchanged, RX_OVERRUN set.
REQ-024 RX_DATA_READ with RX_DATA_VALID = 1 and no load same cycle: RX_DATA_VALID = 0 next cycle; RX_DATA_READ with RX_DATA_VALID = 0 ignored.
REQ-025 ERR_CLEAR clears flags next cycle; a set event in the same cycle wins (flag stays 1).
REQ-026 Latency: RX_DATA_VALID rises 1 cycle after the stop-bit sample cycle.
REQ-027 UART_RTS and RX_IDLE SHALL be combinational from registered state.

Reset
REQ-028 RESET SHALL force: FSM IDLE, counter 0, bitIndex 0, shift register 0x00, RX_DATA 0x00, RX_DATA_VALID 0, RX_FRAME_ERR 0, RX_OVERRUN 0, synchronizer 1, UART_RTS 1, RX_IDLE 1.
REQ-029 RESET asserted mid-frame SHALL abandon the frame with no partial byte reported; after release, reception restarts at the next falling edge of rxs.

Verification
REQ-030 Frame 0x55 (start, 8 data LSB first, stop high) at defaults -> RX_DATA = 0x55, RX_DATA_VALID = 1, flags 0, UART_RTS = 0 until RX_DATA_READ.
REQ-031 RXD low for 100 cycles then high -> START_BIT then IDLE, RX_DATA_VALID stays 0.
REQ-032 Frame 0xA5 with stop bit low, line held low 2000 cycles -> RX_FRAME_ERR = 1, RX_DATA_VALID = 0, FSM in BREAK_WAIT until RXD high; ERR_CLEAR -> RX_FRAME_ERR = 0.
REQ-033 Frames 0x11 then 0x22, no read -> RX_DATA = 0x11, RX_OVERRUN = 1; repeat with RX_DATA_READ on 0x22 load cycle -> RX_DATA = 0x22, RX_OVERRUN unchanged, RX_DATA_VALID = 1.
REQ-034 RESET pulsed during bit 4 of 0xF0 -> all outputs at reset values; following frame 0x3C received correctly.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver with a one-byte holding register,
//                sticky framing/overrun flags and an RTS-style ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       ACLK,
  input  logic       RESET,
  input  logic       RXD,
  output logic [7:0] RX_DATA,
  output logic       RX_DATA_VALID,
  input  logic       RX_DATA_READ,
  output logic       RX_FRAME_ERR,
  output logic       RX_OVERRUN,
  input  logic       ERR_CLEAR,
  output logic       UART_RTS,
  output logic       RX_IDLE
);

  localparam int CLOCKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  // Mid-point of the start bit, used to re-check the line before committing.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  // Last clock of a full bit period; data and stop bits are sampled here.
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    STOP_BIT   = 3'd3,
    BREAK_WAIT = 3'd4
  } state_t;

  logic             rx_meta;
  logic             rxs;
  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_n;
  logic [7:0]       shift;
  logic [7:0]       shift_n;
  logic             frame_good;
  logic             frame_bad;
  logic             load;
  logic             overrun_set;

  // Two-flop synchronizer for the asynchronous line; resets to the idle level.
  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RXD;
      rxs     <= rx_meta;
    end
  end

  // Receiver state, bit timing counter, bit index and shift register.
  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
    end
  end

  // Next-state logic: frame timing and end-of-frame good/bad indications.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxs) begin
          state_n = START_BIT;
          cnt_n   = '0;
        end
      end
      START_BIT: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = 3'd0;
          // A line that is high again at mid-start was a glitch.
          state_n   = rxs ? IDLE : DATA_BITS;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA_BITS: begin
        if (cnt == BIT_LAST) begin
          shift_n[bit_idx] = rxs;
          cnt_n            = '0;
          bit_idx_n        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_n = STOP_BIT;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP_BIT: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rxs) begin
            frame_good = 1'b1;
            state_n    = IDLE;
          end else begin
            // Low stop bit: report and wait out a possible break condition.
            frame_bad = 1'b1;
            state_n   = BREAK_WAIT;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      BREAK_WAIT: begin
        if (rxs) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // A finished byte is accepted if the holder is empty or being emptied now.
  assign load        = frame_good && (!RX_DATA_VALID || RX_DATA_READ);
  assign overrun_set = frame_good && RX_DATA_VALID && !RX_DATA_READ;

  // Holding register and its full flag.
  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      RX_DATA       <= 8'h00;
      RX_DATA_VALID <= 1'b0;
    end else if (load) begin
      RX_DATA       <= shift;
      RX_DATA_VALID <= 1'b1;
    end else if (RX_DATA_READ && RX_DATA_VALID) begin
      RX_DATA_VALID <= 1'b0;
    end
  end

  // Sticky error flags; a new error event takes priority over a clear.
  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      RX_FRAME_ERR <= 1'b0;
      RX_OVERRUN   <= 1'b0;
    end else begin
      if (frame_bad) begin
        RX_FRAME_ERR <= 1'b1;
      end else if (ERR_CLEAR) begin
        RX_FRAME_ERR <= 1'b0;
      end
      if (overrun_set) begin
        RX_OVERRUN <= 1'b1;
      end else if (ERR_CLEAR) begin
        RX_OVERRUN <= 1'b0;
      end
    end
  end

  assign UART_RTS = !RX_DATA_VALID;
  assign RX_IDLE  = (state == IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed self-checking bench for uart_rx at default baud.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CPB  = 50_000_000 / 115200;  // 434 clocks per bit
  localparam int HALF = CPB / 2;              // 217

  logic       ACLK;
  logic       RESET;
  logic       RXD;
  logic [7:0] RX_DATA;
  logic       RX_DATA_VALID;
  logic       RX_DATA_READ;
  logic       RX_FRAME_ERR;
  logic       RX_OVERRUN;
  logic       ERR_CLEAR;
  logic       UART_RTS;
  logic       RX_IDLE;

  int n_checks = 0;
  int n_pass   = 0;

  uart_rx #(
    .CLOCK_FREQ(50_000_000),
    .BAUD_RATE (115200)
  ) dut (
    .ACLK         (ACLK),
    .RESET        (RESET),
    .RXD          (RXD),
    .RX_DATA      (RX_DATA),
    .RX_DATA_VALID(RX_DATA_VALID),
    .RX_DATA_READ (RX_DATA_READ),
    .RX_FRAME_ERR (RX_FRAME_ERR),
    .RX_OVERRUN   (RX_OVERRUN),
    .ERR_CLEAR    (ERR_CLEAR),
    .UART_RTS     (UART_RTS),
    .RX_IDLE      (RX_IDLE)
  );

  initial ACLK = 1'b0;
  always #10 ACLK = ~ACLK;

  // Sends one frame; inputs change on falling edges. The stop bit is sampled
  // at the rising edge following stop-loop step HALF+2, so optional READ/CLEAR
  // pulses are placed exactly on that cycle and VALID must rise right after.
  task automatic send_frame(input logic [7:0] data, input logic stop_val,
                            input logic rd_at_stop, input logic clr_at_stop,
                            input logic chk_lat);
    @(negedge ACLK);
    RXD = 1'b0;
    repeat (CPB) @(negedge ACLK);
    for (int b = 0; b < 8; b++) begin
      RXD = data[b];
      repeat (CPB) @(negedge ACLK);
    end
    RXD = stop_val;
    for (int i = 1; i <= CPB; i++) begin
      @(negedge ACLK);
      if (i == HALF + 2) begin
        RX_DATA_READ = rd_at_stop;
        ERR_CLEAR    = clr_at_stop;
        if (chk_lat) begin
          n_checks++;
          if (RX_DATA_VALID !== 1'b0) $display("FAIL latency_before: valid=%b expected 0", RX_DATA_VALID);
          else n_pass++;
        end
      end else if (i == HALF + 3) begin
        RX_DATA_READ = 1'b0;
        ERR_CLEAR    = 1'b0;
        if (chk_lat) begin
          n_checks++;
          if (RX_DATA_VALID !== 1'b1) $display("FAIL latency_after: valid=%b expected 1", RX_DATA_VALID);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic pulse_read();
    @(negedge ACLK);
    RX_DATA_READ = 1'b1;
    @(negedge ACLK);
    RX_DATA_READ = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge ACLK);
    ERR_CLEAR = 1'b1;
    @(negedge ACLK);
    ERR_CLEAR = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; RXD = 1'b1; RX_DATA_READ = 1'b0; ERR_CLEAR = 1'b0;
    repeat (3) @(negedge ACLK);
    n_checks++; if (RX_DATA !== 8'h00) $display("FAIL reset_data: got %h expected 00", RX_DATA); else n_pass++;
    n_checks++; if (RX_DATA_VALID !== 1'b0) $display("FAIL reset_valid: got %b expected 0", RX_DATA_VALID); else n_pass++;
    n_checks++; if (RX_FRAME_ERR !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", RX_FRAME_ERR); else n_pass++;
    n_checks++; if (RX_OVERRUN !== 1'b0) $display("FAIL reset_ovr: got %b expected 0", RX_OVERRUN); else n_pass++;
    n_checks++; if (UART_RTS !== 1'b1) $display("FAIL reset_rts: got %b expected 1", UART_RTS); else n_pass++;
    n_checks++; if (RX_IDLE !== 1'b1) $display("FAIL reset_idle: got %b expected 1", RX_IDLE); else n_pass++;
    RESET = 1'b0;
    repeat (5) @(negedge ACLK);
  endtask

  task automatic test_good_frame();
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++; if (RX_DATA !== 8'h55) $display("FAIL good_data: got %h expected 55", RX_DATA); else n_pass++;
    n_checks++; if (RX_DATA_VALID !== 1'b1) $display("FAIL good_valid: got %b expected 1", RX_DATA_VALID); else n_pass++;
    n_checks++; if (RX_FRAME_ERR !== 1'b0 || RX_OVERRUN !== 1'b0)
      $display("FAIL good_flags: got ferr=%b ovr=%b expected 0 0", RX_FRAME_ERR, RX_OVERRUN); else n_pass++;
    n_checks++; if (UART_RTS !== 1'b0) $display("FAIL good_rts: got %b expected 0", UART_RTS); else n_pass++;
    n_checks++; if (RX_IDLE !== 1'b1) $display("FAIL good_idle: got %b expected 1", RX_IDLE); else n_pass++;
    pulse_read();
    n_checks++; if (RX_DATA_VALID !== 1'b0) $display("FAIL read_valid: got %b expected 0", RX_DATA_VALID); else n_pass++;
    n_checks++; if (UART_RTS !== 1'b1) $display("FAIL read_rts: got %b expected 1", UART_RTS); else n_pass++;
    n_checks++; if (RX_DATA !== 8'h55) $display("FAIL read_data_kept: got %h expected 55", RX_DATA); else n_pass++;
  endtask

  task automatic test_false_start();
    @(negedge ACLK);
    RXD = 1'b0;
    repeat (50) @(negedge ACLK);
    n_checks++; if (RX_IDLE !== 1'b0) $display("FAIL false_start_busy: idle=%b expected 0", RX_IDLE); else n_pass++;
    repeat (50) @(negedge ACLK);
    RXD = 1'b1;
    repeat (400) @(negedge ACLK);
    n_checks++; if (RX_IDLE !== 1'b1) $display("FAIL false_start_idle: idle=%b expected 1", RX_IDLE); else n_pass++;
    n_checks++; if (RX_DATA_VALID !== 1'b0) $display("FAIL false_start_valid: got %b expected 0", RX_DATA_VALID); else n_pass++;
    n_checks++; if (RX_FRAME_ERR !== 1'b0) $display("FAIL false_start_ferr: got %b expected 0", RX_FRAME_ERR); else n_pass++;
  endtask

  task automatic test_frame_error();
    // ERR_CLEAR coincides with the error event, which must win.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2000) @(negedge ACLK);
    n_checks++; if (RX_FRAME_ERR !== 1'b1) $display("FAIL ferr_set: got %b expected 1", RX_FRAME_ERR); else n_pass++;
    n_checks++; if (RX_DATA_VALID !== 1'b0) $display("FAIL ferr_valid: got %b expected 0", RX_DATA_VALID); else n_pass++;
    n_checks++; if (RX_DATA !== 8'h55) $display("FAIL ferr_data: got %h expected 55", RX_DATA); else n_pass++;
    n_checks++; if (RX_IDLE !== 1'b0) $display("FAIL break_wait: idle=%b expected 0", RX_IDLE); else n_pass++;
    RXD = 1'b1;
    repeat (5) @(negedge ACLK);
    n_checks++; if (RX_IDLE !== 1'b1) $display("FAIL break_release: idle=%b expected 1", RX_IDLE); else n_pass++;
    pulse_clear();
    n_checks++; if (RX_FRAME_ERR !== 1'b0) $display("FAIL ferr_clear: got %b expected 0", RX_FRAME_ERR); else n_pass++;
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if (RX_DATA !== 8'h11) $display("FAIL ovr_data: got %h expected 11", RX_DATA); else n_pass++;
    n_checks++; if (RX_OVERRUN !== 1'b1) $display("FAIL ovr_set: got %b expected 1", RX_OVERRUN); else n_pass++;
    n_checks++; if (RX_DATA_VALID !== 1'b1) $display("FAIL ovr_valid: got %b expected 1", RX_DATA_VALID); else n_pass++;
    // Read lands on the load cycle: new byte replaces the old one.
    send_frame(8'h22, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++; if (RX_DATA !== 8'h22) $display("FAIL rdload_data: got %h expected 22", RX_DATA); else n_pass++;
    n_checks++; if (RX_OVERRUN !== 1'b1) $display("FAIL rdload_ovr: got %b expected 1", RX_OVERRUN); else n_pass++;
    n_checks++; if (RX_DATA_VALID !== 1'b1) $display("FAIL rdload_valid: got %b expected 1", RX_DATA_VALID); else n_pass++;
    pulse_clear();
    n_checks++; if (RX_OVERRUN !== 1'b0) $display("FAIL ovr_clear: got %b expected 0", RX_OVERRUN); else n_pass++;
    pulse_read();
    n_checks++; if (RX_DATA_VALID !== 1'b0) $display("FAIL ovr_read: got %b expected 0", RX_DATA_VALID); else n_pass++;
    pulse_read();
    n_checks++; if (RX_DATA_VALID !== 1'b0 || RX_DATA !== 8'h22)
      $display("FAIL empty_read: got valid=%b data=%h expected 0 22", RX_DATA_VALID, RX_DATA); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] pat;
    pat = 8'hF0;
    @(negedge ACLK);
    RXD = 1'b0;
    repeat (CPB) @(negedge ACLK);
    for (int b = 0; b < 4; b++) begin
      RXD = pat[b];
      repeat (CPB) @(negedge ACLK);
    end
    RXD = pat[4];
    repeat (HALF) @(negedge ACLK);
    n_checks++; if (RX_IDLE !== 1'b0) $display("FAIL mid_busy: idle=%b expected 0", RX_IDLE); else n_pass++;
    RESET = 1'b1;
    #2;
    n_checks++; if (RX_IDLE !== 1'b1) $display("FAIL async_reset_idle: got %b expected 1", RX_IDLE); else n_pass++;
    n_checks++; if (RX_DATA !== 8'h00) $display("FAIL async_reset_data: got %h expected 00", RX_DATA); else n_pass++;
    repeat (3) @(negedge ACLK);
    n_checks++; if (RX_DATA_VALID !== 1'b0 || UART_RTS !== 1'b1)
      $display("FAIL mid_reset_valid: got valid=%b rts=%b expected 0 1", RX_DATA_VALID, UART_RTS); else n_pass++;
    n_checks++; if (RX_FRAME_ERR !== 1'b0 || RX_OVERRUN !== 1'b0)
      $display("FAIL mid_reset_flags: got ferr=%b ovr=%b expected 0 0", RX_FRAME_ERR, RX_OVERRUN); else n_pass++;
    RESET = 1'b0;
    repeat (4 * CPB) @(negedge ACLK);
    n_checks++; if (RX_IDLE !== 1'b1 || RX_DATA_VALID !== 1'b0)
      $display("FAIL post_reset_quiet: got idle=%b valid=%b expected 1 0", RX_IDLE, RX_DATA_VALID); else n_pass++;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++; if (RX_DATA !== 8'h3C) $display("FAIL post_reset_data: got %h expected 3c", RX_DATA); else n_pass++;
    n_checks++; if (RX_DATA_VALID !== 1'b1) $display("FAIL post_reset_valid: got %b expected 1", RX_DATA_VALID); else n_pass++;
    n_checks++; if (RX_FRAME_ERR !== 1'b0 || RX_OVERRUN !== 1'b0)
      $display("FAIL post_reset_flags: got ferr=%b ovr=%b expected 0 0", RX_FRAME_ERR, RX_OVERRUN); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_false_start();
    test_frame_error();
    test_overrun();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
